// File: rtl/echo_range_calc.sv
// echo_range_calc: echo-pulse width to clamped, moving-averaged distance in cm
module echo_range_calc #(
  parameter int CLK_PER_CM = 696,
  parameter int MAX_CM     = 400,
  parameter int AVG_LOG2   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] duration,
  input  logic        dur_valid,
  output logic        busy,
  output logic [15:0] dist_cm,
  output logic        dist_valid,
  output logic        out_of_range,
  output logic        dropped
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PW    = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int SW    = 16 + AVG_LOG2;
  typedef enum logic [1:0] {IDLE, DIV, AVG, OUT} state_t;
  state_t          state_q, state_d;
  logic [4:0]      cnt_q;
  logic [31:0]     dvd_q, quo_q;
  logic [32:0]     rem_q, rem_sh, rem_nx;
  logic            zero_q, ge, oor_raw, primed_q;
  logic [15:0]     sample;
  logic [15:0]     hist_q [DEPTH];
  logic [SW-1:0]   sum_q, sum_nx;
  logic [PW-1:0]   ptr_q, ptr_nx;
  logic [15:0]     dist_q;
  logic            dv_q, oor_q, drop_q;
  assign busy         = state_q != IDLE;
  assign dist_cm      = dist_q;
  assign dist_valid   = dv_q;
  assign out_of_range = oor_q;
  assign dropped      = drop_q;
  // divide step, clamp and filter arithmetic
  always_comb begin
    rem_sh  = {rem_q[31:0], dvd_q[31]};
    ge      = rem_sh >= 33'(CLK_PER_CM);
    rem_nx  = ge ? rem_sh - 33'(CLK_PER_CM) : rem_sh;
    oor_raw = zero_q || quo_q > 32'(MAX_CM);
    sample  = oor_raw ? 16'(MAX_CM) : quo_q[15:0];
    sum_nx  = primed_q ? sum_q - SW'(hist_q[ptr_q]) + SW'(sample) : SW'(sample) << AVG_LOG2;
    ptr_nx  = AVG_LOG2 == 0 ? '0 : ptr_q + 1'b1;
  end
  // next-state logic: accept, 32 divide steps, average, publish
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (dur_valid ? DIV : IDLE) :
              state_q == DIV  ? (cnt_q == 5'd0 ? AVG : DIV) :
              state_q == AVG  ? OUT : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // datapath: divider registers, filter history and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      zero_q   <= 1'b0;
      primed_q <= 1'b0;
      sum_q    <= '0;
      ptr_q    <= '0;
      dist_q   <= '0;
      dv_q     <= 1'b0;
      oor_q    <= 1'b0;
      drop_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else begin
      drop_q <= dur_valid && state_q != IDLE;
      dv_q   <= state_q == AVG;
      if (state_q == IDLE && dur_valid) begin
        dvd_q  <= duration;
        rem_q  <= '0;
        quo_q  <= '0;
        cnt_q  <= 5'd31;
        zero_q <= duration == 32'd0;
      end
      if (state_q == DIV) begin
        dvd_q <= dvd_q << 1;
        rem_q <= rem_nx;
        quo_q <= {quo_q[30:0], ge};
        cnt_q <= cnt_q - 5'd1;
      end
      if (state_q == AVG) begin
        sum_q    <= sum_nx;
        primed_q <= 1'b1;
        dist_q   <= 16'(sum_nx >> AVG_LOG2);
        oor_q    <= oor_raw;
        if (primed_q) begin
          hist_q[ptr_q] <= sample;
          ptr_q         <= ptr_nx;
        end else begin
          for (int i = 0; i < DEPTH; i++) hist_q[i] <= sample;
        end
      end
    end
  end
endmodule

// File: tb/tb_echo_range_calc.sv
// tb_echo_range_calc: directed checks of conversion, clamping, averaging, drops and reset
module tb_echo_range_calc;
  logic        clk = 1'b0;
  logic        rst, dur_valid, busy, dist_valid, out_of_range, dropped;
  logic [31:0] duration;
  logic [15:0] dist_cm;
  int          vectors = 0, miscompares = 0;
  echo_range_calc dut (
    .clk(clk), .rst(rst), .duration(duration), .dur_valid(dur_valid), .busy(busy),
    .dist_cm(dist_cm), .dist_valid(dist_valid), .out_of_range(out_of_range), .dropped(dropped)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic measure(input logic [31:0] d, input logic [15:0] ed, input logic eo, input string tag);
    int n;
    duration  = d;
    dur_valid = 1'b1;
    @(posedge clk); #1;
    dur_valid = 1'b0;
    n = 1;
    chk({tag, "_busy"}, 32'(busy), 1);
    while (!dist_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 34);
    chk({tag, "_dist"}, dist_cm, ed);
    chk({tag, "_oor"}, 32'(out_of_range), 32'(eo));
    @(posedge clk); #1;
    chk({tag, "_vld_off"}, 32'(dist_valid), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_hold"}, dist_cm, ed);
  endtask
  initial begin
    int pulses, at;
    rst = 1'b1; dur_valid = 1'b0; duration = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_dist", dist_cm, 0);
    chk("rst_vld", 32'(dist_valid), 0);
    chk("rst_oor", 32'(out_of_range), 0);
    chk("rst_drop", 32'(dropped), 0);
    chk("rst_busy", 32'(busy), 0);
    measure(32'd6960, 16'd10, 1'b0, "prime10");
    measure(32'd13920, 16'd12, 1'b0, "avg20");
    measure(32'd20880, 16'd17, 1'b0, "avg30");
    measure(32'd27840, 16'd25, 1'b0, "avg40");
    measure(32'd34800, 16'd35, 1'b0, "avg50");
    measure(32'd41760, 16'd45, 1'b0, "wrap60");
    duration = 32'd6960; dur_valid = 1'b1;
    @(posedge clk); #1;
    dur_valid = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 45; n++) begin
      rst = n == 10;
      if (n == 11) begin
        chk("abort_busy", 32'(busy), 0);
        chk("abort_dist", dist_cm, 0);
        chk("abort_oor", 32'(out_of_range), 0);
      end
      if (dist_valid) pulses++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    chk("abort_no_vld", pulses, 0);
    measure(32'd6960, 16'd10, 1'b0, "reprime");
    rst = 1'b1; dur_valid = 1'b1; duration = 32'd6960;
    @(posedge clk); #1;
    rst = 1'b0; dur_valid = 1'b0;
    chk("rst_prio_busy", 32'(busy), 0);
    do_reset();
    measure(32'd278400, 16'd400, 1'b0, "max400");
    do_reset();
    measure(32'd279096, 16'd400, 1'b1, "clamp401");
    do_reset();
    measure(32'd0, 16'd400, 1'b1, "zero");
    do_reset();
    measure(32'd695, 16'd0, 1'b0, "sub1cm");
    do_reset();
    duration = 32'd13920; dur_valid = 1'b1;
    @(posedge clk); #1;
    dur_valid = 1'b0;
    pulses = 0; at = 0;
    for (int n = 1; n <= 40; n++) begin
      dur_valid = n == 5 || n == 34;
      duration  = 32'd6960;
      if (n == 6) chk("drop_pulse", 32'(dropped), 1);
      if (n == 7) chk("drop_one_cyc", 32'(dropped), 0);
      if (n == 35) chk("drop_at_out", 32'(dropped), 1);
      if (n == 36) chk("drop_out_idle", 32'(busy), 0);
      if (dist_valid) begin
        pulses++;
        at = n;
        chk("drop_dist", dist_cm, 20);
      end
      @(posedge clk); #1;
    end
    dur_valid = 1'b0;
    chk("drop_count", pulses, 1);
    chk("drop_lat", at, 34);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/echo_range_calc.md
# echo_range_calc

Converts each raw echo-pulse duration from the echo timer into a filtered distance in centimetres for the LED controller and any later reporting logic. It sits between the echo timer and the LED controller. A sequential restoring divider does the conversion, the result is clamped to the sensor range, and a power-of-two moving average smooths the output. Each accepted measurement produces exactly one `dist_valid` pulse.

## Interface
- `CLK_PER_CM`, default 696: clock cycles per cm of range (12 MHz × 58 µs).
- `MAX_CM`, default 400: maximum reportable distance, which is also the clamp value.
- `AVG_LOG2`, default 2: log2 of the moving-average depth (default 4 samples). Legal range 0..3.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `duration`  in  32  echo width in clock cycles, sampled when `dur_valid`=1.
- `dur_valid`  in  1  one-cycle strobe: a new `duration` is available.
- `busy`  out  1  high while a measurement is in flight (state ≠ IDLE).
- `dist_cm`  out  16  filtered distance; held between updates.
- `dist_valid`  out  1  one-cycle strobe: `dist_cm` has been updated.
- `out_of_range`  out  1  the latest raw sample was clamped; updates together with `dist_cm`.
- `dropped`  out  1  one-cycle strobe: a `dur_valid` arrived while busy and was ignored.

## Operation
- State machine:
  - IDLE: if `dur_valid`=1, latch `duration`, clear the remainder and quotient, and go to DIV.
  - DIV: one restoring-divide step per cycle over 32 cycles (bit counter 31→0). Divisor is `CLK_PER_CM`, giving a 32-bit quotient. After the final step, go to AVG.
  - AVG: clamp the sample and update the average history. Go to OUT.
  - OUT: register `dist_cm`, `out_of_range`, and `dist_valid`=1. Go to IDLE.
- Raw sample:
  - q = floor(duration / CLK_PER_CM).
  - If q > MAX_CM, or duration == 0 (no echo / timeout): sample = MAX_CM and oor = 1.
  - Otherwise sample = q[15:0] and oor = 0.
- Moving average:
  - History has 2^AVG_LOG2 entries of 16 bits, plus a running sum of 16+AVG_LOG2 bits.
  - The first sample after reset primes the filter: every entry is set to the sample and sum = sample << AVG_LOG2.
  - Each later sample: sum = sum − oldest + sample, the sample replaces the oldest entry, and the write pointer wraps modulo depth.
  - `dist_cm` = sum >> AVG_LOG2 (floor).
- `out_of_range` reflects the raw sample only, not the average.
- `dur_valid` while `busy`=1 is ignored. `dropped` pulses on the next cycle. The in-flight measurement is not disturbed.

## Timing
- Reset values:
  - `dist_cm`=0, `dist_valid`=0, `out_of_range`=0, `dropped`=0, `busy`=0.
  - History, sum, pointer, and primed flag are all cleared. State is IDLE.
- Latency: `dur_valid` accepted at cycle T gives `dist_valid`=1 at T+34.
  - DIV covers T+1..T+32, AVG is T+33, OUT is T+34.
  - `dist_cm` and `out_of_range` are valid from T+34 and held until the next update.
- `busy` is high from T+1 through T+34. The earliest next acceptance is T+35, so maximum throughput is one sample per 35 cycles.
- `dur_valid` at exactly T+34 (state OUT) is dropped; `dropped` pulses at T+35.
- Reset mid-operation (any state) aborts the measurement: no `dist_valid` is produced and all values return to reset values the cycle after `rst`.
- `rst` has priority over `dur_valid` in the same cycle.

## Test plan
- Reset, then `duration`=6960 → `dist_valid` exactly 34 cycles after the strobe, `dist_cm`=10, `out_of_range`=0 (priming: the first output is unaveraged).
- Following the first case, send `duration`=13920 → `dist_cm`=12, i.e. (10·3+20)/4 = 12.5 floored.
- Boundary checks:
  - `duration`=278400 → raw 400, `out_of_range`=0.
  - `duration`=279096 → raw 401, clamped to 400, `out_of_range`=1.
  - `duration`=0 → `out_of_range`=1.
  - `duration`=695 → raw 0, `out_of_range`=0.
- `dur_valid` at T and again at T+5 → `dropped`=1 at T+6, one `dist_valid` only at T+34, with the first sample's value.
- `dur_valid` at T, `rst` at T+10 → no `dist_valid` ever appears, outputs return to 0, `busy`=0 at T+11. The next sample re-primes the filter.
- 4-sample history wrap: feed 10, 20, 30, 40, 50 cm (after priming with 10) → `dist_cm` sequence 10, 12, 17, 25, 35.
